// File: rtl/ex_stage_pkg.sv
// Shared pipeline definitions for the execute stage: ID/EX and EX/MEM bus layouts,
// ALU function groups/codes and destination/result select codes.
package ex_stage_pkg;

    localparam int unsigned ID_EX_W  = 231;
    localparam int unsigned EX_MEM_W = 107;

    typedef enum logic [1:0] {
        ALU_ARITH = 2'b00,
        ALU_LOGIC = 2'b01,
        ALU_SHIFT = 2'b10,
        ALU_CMP   = 2'b11
    } alu_grp_e;

    typedef enum logic [3:0] {
        LOGIC_NOR  = 4'b0001,
        LOGIC_XOR  = 4'b0110,
        LOGIC_AND  = 4'b1000,
        LOGIC_PASS = 4'b1010,
        LOGIC_OR   = 4'b1110
    } alu_logic_e;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b11
    } alu_shift_e;

    typedef enum logic [2:0] {
        CMP_NE  = 3'b000,
        CMP_EQ  = 3'b001,
        CMP_LT  = 3'b010,
        CMP_LTZ = 3'b101,
        CMP_LEZ = 3'b110,
        CMP_GTZ = 3'b111
    } alu_cmp_e;

    typedef enum logic [1:0] {
        REGDST_RD = 2'b00,
        REGDST_RT = 2'b01,
        REGDST_RA = 2'b10,
        REGDST_XP = 2'b11
    } regdst_e;

    localparam logic [1:0] M2R_PC4 = 2'b10;

    // Field order is MSB first, so the packed struct maps 1:1 onto the bus bits.
    typedef struct packed {
        logic        jump;        // [230]
        regdst_e     reg_dst;     // [229:228]
        logic        branch;      // [227]
        logic [31:0] imm32;       // [226:195]
        logic [4:0]  shamt;       // [194:190]
        logic [31:0] pc_plus4;    // [189:158]
        logic        lu_op;       // [157]
        logic [31:0] lu_data;     // [156:125]
        logic [1:0]  mem_to_reg;  // [124:123]
        logic        reg_write;   // [122]
        logic        mem_read;    // [121]
        logic        mem_write;   // [120]
        logic [31:0] br_target;   // [119:88]
        logic        alu_src1;    // [87]
        logic        alu_src2;    // [86]
        logic [5:0]  alu_fun;     // [85:80]
        logic        sign;        // [79]
        logic [4:0]  rd;          // [78:74]
        logic [4:0]  rt;          // [73:69]
        logic [4:0]  rs;          // [68:64]
        logic [31:0] rt_data;     // [63:32]
        logic [31:0] rs_data;     // [31:0]
    } id_ex_t;

    typedef struct packed {
        logic        br_taken;    // [106]
        logic [31:0] pc_plus4;    // [105:74]
        logic        mem_read;    // [73]
        logic        mem_write;   // [72]
        logic [1:0]  mem_to_reg;  // [71:70]
        logic        reg_write;   // [69]
        logic [4:0]  wreg;        // [68:64]
        logic [31:0] store_data;  // [63:32]
        logic [31:0] result;      // [31:0]
    } ex_mem_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: arithmetic, logic, shift and compare groups selected by ALUFun.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  alu_fun,
    input  logic        sign,
    output logic [31:0] alu_out
);

    logic        lt;
    logic        a_zero;
    logic [4:0]  sh;

    assign a_zero = (a == '0);
    assign sh     = a[4:0];

    always_comb begin
        if (sign) begin
            lt = $signed(a) < $signed(b);
        end else begin
            lt = a < b;
        end
    end

    always_comb begin
        alu_out = '0;
        case (alu_grp_e'(alu_fun[5:4]))
            ALU_ARITH: alu_out = alu_fun[0] ? (a - b) : (a + b);
            ALU_LOGIC: begin
                case (alu_fun[3:0])
                    LOGIC_AND:  alu_out = a & b;
                    LOGIC_OR:   alu_out = a | b;
                    LOGIC_XOR:  alu_out = a ^ b;
                    LOGIC_NOR:  alu_out = ~(a | b);
                    LOGIC_PASS: alu_out = a;
                    default:    alu_out = '0;
                endcase
            end
            ALU_SHIFT: begin
                case (alu_fun[1:0])
                    SHIFT_SLL: alu_out = b << sh;
                    SHIFT_SRL: alu_out = b >> sh;
                    SHIFT_SRA: alu_out = $signed(b) >>> sh;
                    default:   alu_out = '0;
                endcase
            end
            ALU_CMP: begin
                // Zero-tests look at A only; LEZ/GTZ split on sign bit plus zero.
                case (alu_fun[3:1])
                    CMP_EQ:  alu_out[0] = (a == b);
                    CMP_NE:  alu_out[0] = (a != b);
                    CMP_LT:  alu_out[0] = lt;
                    CMP_LEZ: alu_out[0] = a[31] | a_zero;
                    CMP_LTZ: alu_out[0] = a[31];
                    CMP_GTZ: alu_out[0] = ~a[31] & ~a_zero;
                    default: alu_out    = '0;
                endcase
            end
            default: alu_out = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch resolve, write-back select
// and the EX/MEM pipeline register.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter logic [4:0] XP_REG = 5'd26,
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic [ID_EX_W-1:0]  ID_EX,
    input  logic                MEM_WB_RegWrite,
    input  logic [4:0]          MEM_WB_Rd,
    input  logic [31:0]         MEM_WB_RdData,
    input  logic                EX_Flush,
    input  logic                EX_Hold,
    output logic [4:0]          ID_EX_Rt,
    output logic                ID_EX_MemRead,
    output logic                EX_Branch,
    output logic                EX_Jump,
    output logic [31:0]         EX_PC_Plus4,
    output logic [31:0]         branch_target,
    output logic                EX_MEM_RegWrite,
    output logic [4:0]          EX_MEM_Rd,
    output logic [31:0]         EX_MEM_RdData,
    output logic [EX_MEM_W-1:0] EX_MEM
);

    id_ex_t      id;
    ex_mem_t     ex_mem_q;
    ex_mem_t     ex_mem_d;
    ex_mem_t     ex_mem_new;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic [4:0]  wreg;

    assign id = id_ex_t'(ID_EX);

    // EX/MEM takes priority over MEM/WB since it holds the younger value.
    always_comb begin
        fwd_rs = id.rs_data;
        if (id.rs != '0) begin
            if (ex_mem_q.reg_write && ex_mem_q.wreg == id.rs) begin
                fwd_rs = ex_mem_q.result;
            end else if (MEM_WB_RegWrite && MEM_WB_Rd == id.rs) begin
                fwd_rs = MEM_WB_RdData;
            end
        end
    end

    always_comb begin
        fwd_rt = id.rt_data;
        if (id.rt != '0) begin
            if (ex_mem_q.reg_write && ex_mem_q.wreg == id.rt) begin
                fwd_rt = ex_mem_q.result;
            end else if (MEM_WB_RegWrite && MEM_WB_Rd == id.rt) begin
                fwd_rt = MEM_WB_RdData;
            end
        end
    end

    assign op_a = id.alu_src1 ? {27'b0, id.shamt} : fwd_rs;
    assign op_b = id.alu_src2 ? id.imm32 : fwd_rt;

    ex_alu u_alu (
        .a       (op_a),
        .b       (op_b),
        .alu_fun (id.alu_fun),
        .sign    (id.sign),
        .alu_out (alu_out)
    );

    always_comb begin
        wreg = id.rd;
        case (id.reg_dst)
            REGDST_RD: wreg = id.rd;
            REGDST_RT: wreg = id.rt;
            REGDST_RA: wreg = RA_REG;
            REGDST_XP: wreg = XP_REG;
            default:   wreg = id.rd;
        endcase
    end

    always_comb begin
        ex_mem_new            = '0;
        ex_mem_new.br_taken   = EX_Branch;
        ex_mem_new.pc_plus4   = id.pc_plus4;
        ex_mem_new.mem_read   = id.mem_read;
        ex_mem_new.mem_write  = id.mem_write;
        ex_mem_new.mem_to_reg = id.mem_to_reg;
        ex_mem_new.reg_write  = id.reg_write;
        ex_mem_new.wreg       = wreg;
        ex_mem_new.store_data = fwd_rt;
        if (id.mem_to_reg == M2R_PC4) begin
            ex_mem_new.result = id.pc_plus4;
        end else if (id.lu_op) begin
            ex_mem_new.result = id.lu_data;
        end else begin
            ex_mem_new.result = alu_out;
        end
    end

    always_comb begin
        ex_mem_d = ex_mem_new;
        if (EX_Flush) begin
            ex_mem_d = '0;
        end else if (EX_Hold) begin
            ex_mem_d = ex_mem_q;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign EX_Branch       = id.branch & alu_out[0];
    assign EX_Jump         = id.jump;
    assign EX_PC_Plus4     = id.pc_plus4;
    assign branch_target   = id.br_target;
    assign ID_EX_Rt        = id.rt;
    assign ID_EX_MemRead   = id.mem_read;
    assign EX_MEM          = ex_mem_q;
    assign EX_MEM_RegWrite = ex_mem_q.reg_write;
    assign EX_MEM_Rd       = ex_mem_q.wreg;
    assign EX_MEM_RdData   = ex_mem_q.result;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed vector table, hand-written control
// sequences and randomized traffic against a behavioural reference model.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         reset_b;
    logic [230:0] ID_EX;
    logic         MEM_WB_RegWrite;
    logic [4:0]   MEM_WB_Rd;
    logic [31:0]  MEM_WB_RdData;
    logic         EX_Flush;
    logic         EX_Hold;
    logic [4:0]   ID_EX_Rt;
    logic         ID_EX_MemRead;
    logic         EX_Branch;
    logic         EX_Jump;
    logic [31:0]  EX_PC_Plus4;
    logic [31:0]  branch_target;
    logic         EX_MEM_RegWrite;
    logic [4:0]   EX_MEM_Rd;
    logic [31:0]  EX_MEM_RdData;
    logic [106:0] EX_MEM;

    int checks = 0;
    int errors = 0;
    logic [106:0] exp_mem;

    always #5 clk = ~clk;

    ex_stage #(.XP_REG(5'd26), .RA_REG(5'd31)) dut (
        .clk             (clk),
        .reset_b         (reset_b),
        .ID_EX           (ID_EX),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .MEM_WB_Rd       (MEM_WB_Rd),
        .MEM_WB_RdData   (MEM_WB_RdData),
        .EX_Flush        (EX_Flush),
        .EX_Hold         (EX_Hold),
        .ID_EX_Rt        (ID_EX_Rt),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .EX_Branch       (EX_Branch),
        .EX_Jump         (EX_Jump),
        .EX_PC_Plus4     (EX_PC_Plus4),
        .branch_target   (branch_target),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .EX_MEM_Rd       (EX_MEM_Rd),
        .EX_MEM_RdData   (EX_MEM_RdData),
        .EX_MEM          (EX_MEM)
    );

    typedef struct {
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] rs_data, rt_data, btarget, ludata, pc4, imm;
        logic        alusrc1, alusrc2, sign, memread, memwrite, regwrite, luop, branch, jump;
        logic [5:0]  alufun;
        logic [1:0]  memtoreg, regdst;
    } id_fields_t;

    typedef struct {
        id_fields_t  f;
        logic [31:0] exp_res;
        logic [4:0]  exp_wreg;
        logic        exp_rw;
        logic        exp_br;
    } vec_t;

    vec_t vecs[13];

    function automatic id_fields_t alu_op(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [31:0] rsd,
                                          input logic [31:0] rtd, input logic [5:0] fun,
                                          input logic rw);
        id_fields_t f;
        f = '{default: '0};
        f.rs = rs; f.rt = rt; f.rd = rd; f.rs_data = rsd; f.rt_data = rtd;
        f.alufun = fun; f.regwrite = rw;
        return f;
    endfunction

    function automatic logic [230:0] pack(input id_fields_t f);
        logic [230:0] v;
        v = '0;
        v[31:0] = f.rs_data;     v[63:32] = f.rt_data;   v[68:64] = f.rs;
        v[73:69] = f.rt;         v[78:74] = f.rd;        v[79] = f.sign;
        v[85:80] = f.alufun;     v[86] = f.alusrc2;      v[87] = f.alusrc1;
        v[119:88] = f.btarget;   v[120] = f.memwrite;    v[121] = f.memread;
        v[122] = f.regwrite;     v[124:123] = f.memtoreg; v[156:125] = f.ludata;
        v[157] = f.luop;         v[189:158] = f.pc4;     v[194:190] = f.shamt;
        v[226:195] = f.imm;      v[227] = f.branch;      v[229:228] = f.regdst;
        v[230] = f.jump;
        return v;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] fun, input logic sgn);
        logic [31:0] r;
        logic        flag;
        r = 32'd0;
        flag = 1'b0;
        case (fun[5:4])
            2'd0: r = fun[0] ? a - b : a + b;
            2'd1: case (fun[3:0])
                4'd8:  r = a & b;
                4'd14: r = a | b;
                4'd6:  r = a ^ b;
                4'd1:  r = ~(a | b);
                4'd10: r = a;
                default: r = 32'd0;
            endcase
            2'd2: case (fun[1:0])
                2'd0: r = b << a[4:0];
                2'd1: r = b >> a[4:0];
                2'd3: r = $signed(b) >>> a[4:0];
                default: r = 32'd0;
            endcase
            default: begin
                case (fun[3:1])
                    3'd1: flag = (a == b);
                    3'd0: flag = (a != b);
                    3'd2: if (sgn) flag = ($signed(a) < $signed(b)); else flag = (a < b);
                    3'd6: flag = ($signed(a) <= 0);
                    3'd5: flag = ($signed(a) < 0);
                    3'd7: flag = ($signed(a) > 0);
                    default: flag = 1'b0;
                endcase
                r = {31'd0, flag};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] d,
                                            input logic [106:0] prev, input logic wbwe,
                                            input logic [4:0] wbrd, input logic [31:0] wbd);
        if (r == 5'd0) return d;
        if (prev[69] && prev[68:64] == r) return prev[31:0];
        if (wbwe && wbrd == r) return wbd;
        return d;
    endfunction

    function automatic logic [106:0] ref_next(input logic [230:0] x, input logic [106:0] prev,
                                              input logic wbwe, input logic [4:0] wbrd,
                                              input logic [31:0] wbd);
        logic [31:0] fa, fb, a, b, alu, res;
        logic [4:0]  wreg;
        logic        br;
        fa = ref_fwd(x[68:64], x[31:0], prev, wbwe, wbrd, wbd);
        fb = ref_fwd(x[73:69], x[63:32], prev, wbwe, wbrd, wbd);
        a = x[87] ? {27'd0, x[194:190]} : fa;
        b = x[86] ? x[226:195] : fb;
        alu = ref_alu(a, b, x[85:80], x[79]);
        br = x[227] & alu[0];
        case (x[229:228])
            2'd0: wreg = x[78:74];
            2'd1: wreg = x[73:69];
            2'd2: wreg = 5'd31;
            default: wreg = 5'd26;
        endcase
        if (x[124:123] == 2'd2) res = x[189:158];
        else if (x[157]) res = x[156:125];
        else res = alu;
        return {br, x[189:158], x[121], x[120], x[124:123], x[122], wreg, fb, res};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One pipeline beat: drive at negedge, check combinational outputs, then the register.
    task automatic drive(input logic [230:0] x, input logic wbwe, input logic [4:0] wbrd,
                         input logic [31:0] wbd, input logic fl, input logic ho);
        logic [106:0] nxt;
        @(negedge clk);
        ID_EX = x; MEM_WB_RegWrite = wbwe; MEM_WB_Rd = wbrd; MEM_WB_RdData = wbd;
        EX_Flush = fl; EX_Hold = ho;
        nxt = ref_next(x, exp_mem, wbwe, wbrd, wbd);
        #1;
        check("ex_branch", {127'd0, EX_Branch}, {127'd0, nxt[106]});
        check("branch_target", {96'd0, branch_target}, {96'd0, x[119:88]});
        check("passthru", {90'd0, EX_Jump, EX_PC_Plus4, ID_EX_Rt, ID_EX_MemRead},
              {90'd0, x[230], x[189:158], x[73:69], x[121]});
        @(posedge clk);
        if (fl) exp_mem = '0;
        else if (!ho) exp_mem = nxt;
        #1;
        check("ex_mem", {21'd0, EX_MEM}, {21'd0, exp_mem});
        check("ex_mem_derived", {89'd0, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData},
              {89'd0, exp_mem[69], exp_mem[68:64], exp_mem[31:0]});
    endtask

    logic [5:0] fun_list[16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110,
                                 6'b010001, 6'b011010, 6'b100000, 6'b100001, 6'b100011,
                                 6'b110011, 6'b110001, 6'b110101, 6'b111101, 6'b111011,
                                 6'b111111};

    initial begin
        id_fields_t f;
        logic [106:0] held;

        reset_b = 1'b0; ID_EX = '0; MEM_WB_RegWrite = 1'b0; MEM_WB_Rd = '0;
        MEM_WB_RdData = '0; EX_Flush = 1'b0; EX_Hold = 1'b0; exp_mem = '0;

        vecs[0].f = alu_op(5, 6, 10, 32'd7, 32'd3, 6'b000000, 1'b1);
        vecs[0].exp_res = 32'd10; vecs[0].exp_wreg = 5'd10; vecs[0].exp_rw = 1; vecs[0].exp_br = 0;
        vecs[1].f = alu_op(1, 2, 11, 32'd5, 32'd7, 6'b000001, 1'b1);
        vecs[1].exp_res = 32'hFFFF_FFFE; vecs[1].exp_wreg = 5'd11; vecs[1].exp_rw = 1; vecs[1].exp_br = 0;
        vecs[2].f = alu_op(3, 4, 0, 32'h1234, 32'h1234, 6'b110011, 1'b0);
        vecs[2].f.branch = 1'b1; vecs[2].f.btarget = 32'h0040_0100;
        vecs[2].exp_res = 32'd1; vecs[2].exp_wreg = 5'd0; vecs[2].exp_rw = 0; vecs[2].exp_br = 1;
        vecs[3].f = alu_op(3, 4, 0, 32'h1234, 32'h1234, 6'b110001, 1'b0);
        vecs[3].f.branch = 1'b1; vecs[3].f.btarget = 32'h0040_0200;
        vecs[3].exp_res = 32'd0; vecs[3].exp_wreg = 5'd0; vecs[3].exp_rw = 0; vecs[3].exp_br = 0;
        vecs[4].f = alu_op(7, 8, 14, 32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b1);
        vecs[4].f.sign = 1'b1;
        vecs[4].exp_res = 32'd1; vecs[4].exp_wreg = 5'd14; vecs[4].exp_rw = 1; vecs[4].exp_br = 0;
        vecs[5].f = alu_op(7, 8, 14, 32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b1);
        vecs[5].exp_res = 32'd0; vecs[5].exp_wreg = 5'd14; vecs[5].exp_rw = 1; vecs[5].exp_br = 0;
        vecs[6].f = alu_op(0, 0, 0, 32'd0, 32'd0, 6'b000000, 1'b1);
        vecs[6].f.regdst = 2'b10; vecs[6].f.memtoreg = 2'b10; vecs[6].f.pc4 = 32'h0040_0008;
        vecs[6].f.jump = 1'b1;
        vecs[6].exp_res = 32'h0040_0008; vecs[6].exp_wreg = 5'd31; vecs[6].exp_rw = 1; vecs[6].exp_br = 0;
        vecs[7].f = alu_op(0, 9, 0, 32'd0, 32'd0, 6'b000000, 1'b1);
        vecs[7].f.luop = 1'b1; vecs[7].f.ludata = 32'hABCD_0000; vecs[7].f.regdst = 2'b01;
        vecs[7].exp_res = 32'hABCD_0000; vecs[7].exp_wreg = 5'd9; vecs[7].exp_rw = 1; vecs[7].exp_br = 0;
        vecs[8].f = alu_op(0, 12, 13, 32'd0, 32'h8000_0000, 6'b100011, 1'b1);
        vecs[8].f.alusrc1 = 1'b1; vecs[8].f.shamt = 5'd4;
        vecs[8].exp_res = 32'hF800_0000; vecs[8].exp_wreg = 5'd13; vecs[8].exp_rw = 1; vecs[8].exp_br = 0;
        vecs[9].f = alu_op(15, 16, 17, 32'h0F0F_0000, 32'h00FF_00FF, 6'b010001, 1'b1);
        vecs[9].exp_res = 32'hF000_FF00; vecs[9].exp_wreg = 5'd17; vecs[9].exp_rw = 1; vecs[9].exp_br = 0;
        vecs[10].f = alu_op(18, 0, 19, 32'h1234_0000, 32'd0, 6'b011110, 1'b1);
        vecs[10].f.alusrc2 = 1'b1; vecs[10].f.imm = 32'h0000_FFFF;
        vecs[10].exp_res = 32'h1234_FFFF; vecs[10].exp_wreg = 5'd19; vecs[10].exp_rw = 1; vecs[10].exp_br = 0;
        vecs[11].f = alu_op(20, 21, 0, 32'd1, 32'd2, 6'b000000, 1'b1);
        vecs[11].f.regdst = 2'b11;
        vecs[11].exp_res = 32'd3; vecs[11].exp_wreg = 5'd26; vecs[11].exp_rw = 1; vecs[11].exp_br = 0;
        vecs[12].f = alu_op(0, 0, 0, 32'd0, 32'd0, 6'b000000, 1'b0);
        vecs[12].exp_res = 32'd0; vecs[12].exp_wreg = 5'd0; vecs[12].exp_rw = 0; vecs[12].exp_br = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_mem", {21'd0, EX_MEM}, 128'd0);
        check("reset_derived", {89'd0, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData}, 128'd0);
        @(negedge clk);
        reset_b = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(pack(vecs[i].f), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
            check($sformatf("vec%0d_result", i), {96'd0, EX_MEM_RdData}, {96'd0, vecs[i].exp_res});
            check($sformatf("vec%0d_wreg", i), {123'd0, EX_MEM_Rd}, {123'd0, vecs[i].exp_wreg});
            check($sformatf("vec%0d_ctl", i), {124'd0, EX_MEM_RegWrite, EX_MEM[106], EX_MEM[73:72]},
                  {124'd0, vecs[i].exp_rw, vecs[i].exp_br, 2'b00});
        end

        // Back-to-back dependency: EX/MEM beats MEM/WB, then MEM/WB alone, then r0.
        drive(pack(alu_op(1, 0, 5, 32'h100, 32'd0, 6'b000000, 1'b1)), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        drive(pack(alu_op(5, 5, 6, 32'd7, 32'd3, 6'b000000, 1'b1)), 1'b1, 5'd5, 32'h200, 1'b0, 1'b0);
        check("fwd_exmem_result", {96'd0, EX_MEM_RdData}, 128'h200);
        check("fwd_exmem_store", {96'd0, EX_MEM[63:32]}, 128'h100);
        f = alu_op(5, 0, 7, 32'd7, 32'd0, 6'b000000, 1'b1);
        drive(pack(f), 1'b1, 5'd5, 32'h200, 1'b0, 1'b0);
        check("fwd_memwb_result", {96'd0, EX_MEM_RdData}, 128'h200);
        drive(pack(alu_op(1, 0, 0, 32'h55, 32'd0, 6'b000000, 1'b1)), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        drive(pack(alu_op(0, 0, 8, 32'd9, 32'd0, 6'b000000, 1'b1)), 1'b1, 5'd0, 32'h77, 1'b0, 1'b0);
        check("fwd_r0_ignored", {96'd0, EX_MEM_RdData}, 128'd9);

        // Hold for two cycles, then flush together with hold.
        drive(pack(vecs[0].f), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        held = EX_MEM;
        drive(pack(vecs[1].f), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        drive(pack(vecs[9].f), 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        check("hold_stable", {21'd0, EX_MEM}, {21'd0, exp_mem});
        check("hold_value", {96'd0, EX_MEM_RdData}, 128'd10);
        drive(pack(vecs[1].f), 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        check("flush_over_hold", {21'd0, EX_MEM}, 128'd0);

        // Asynchronous reset while holding.
        drive(pack(vecs[0].f), 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        EX_Hold = 1'b1;
        #2 reset_b = 1'b0;
        #1;
        exp_mem = '0;
        check("async_reset_ex_mem", {21'd0, EX_MEM}, 128'd0);
        check("async_reset_derived", {89'd0, EX_MEM_RegWrite, EX_MEM_Rd, EX_MEM_RdData}, 128'd0);
        @(negedge clk);
        reset_b = 1'b1; EX_Hold = 1'b0;

        for (int n = 0; n < 400; n++) begin
            logic [230:0] x;
            f = '{default: '0};
            f.rs = 5'($urandom_range(0, 7)); f.rt = 5'($urandom_range(0, 7));
            f.rd = 5'($urandom_range(0, 7)); f.shamt = 5'($urandom);
            f.rs_data = $urandom; f.rt_data = $urandom; f.btarget = $urandom;
            f.ludata = $urandom; f.pc4 = $urandom; f.imm = $urandom;
            f.rs_data = ($urandom_range(0, 3) == 0) ? f.rt_data : f.rs_data;
            f.alusrc1 = 1'($urandom); f.alusrc2 = 1'($urandom); f.sign = 1'($urandom);
            f.memread = 1'($urandom); f.memwrite = 1'($urandom); f.regwrite = 1'($urandom);
            f.luop = ($urandom_range(0, 3) == 0); f.branch = 1'($urandom); f.jump = 1'($urandom);
            f.memtoreg = 2'($urandom); f.regdst = 2'($urandom);
            f.alufun = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fun_list[$urandom_range(0, 15)];
            x = ($urandom_range(0, 15) == 0) ? '0 : pack(f);
            drive(x, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It is the consumer of the 231-bit ID/EX pipeline bus.
- Re-forwards Rs/Rt operands from EX/MEM and MEM/WB, runs the ALU, resolves conditional branches, selects the destination register and write-back value.
- Registers everything into the EX/MEM pipeline bus. Exports the hazard, forwarding and branch signals the decode stage consumes.

Parameters:
- XP_REG, 5'd26, destination register index for RegDst=11 (interrupt/exception return address).
- RA_REG, 5'd31, destination register index for RegDst=10 (link).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- ID_EX  input  231  ID/EX bus, layout below.
- MEM_WB_RegWrite  input  1  WB-stage write enable.
- MEM_WB_Rd  input  5  WB-stage destination register.
- MEM_WB_RdData  input  32  WB-stage write data.
- EX_Flush  input  1  zero the EX/MEM bus next edge (interrupt/exception).
- EX_Hold  input  1  keep EX/MEM unchanged next edge (MEM-side stall).
- ID_EX_Rt  output  5  ID_EX[73:69], for load-use detection.
- ID_EX_MemRead  output  1  ID_EX[121].
- EX_Branch  output  1  branch taken (combinational).
- EX_Jump  output  1  ID_EX[230].
- EX_PC_Plus4  output  32  ID_EX[189:158].
- branch_target  output  32  ID_EX[119:88]; valid when EX_Branch=1.
- EX_MEM_RegWrite  output  1  EX_MEM[69].
- EX_MEM_Rd  output  5  EX_MEM[68:64].
- EX_MEM_RdData  output  32  EX_MEM[31:0].
- EX_MEM  output reg  107  EX/MEM bus.

Behaviour:
- ID_EX layout:
  - [31:0] RsData, [63:32] RtData, [68:64] Rs, [73:69] Rt, [78:74] Rd
  - [87] ALUSrc1, [86] ALUSrc2, [85:80] ALUFun, [79] Sign
  - [119:88] branch target, [121] MemRead, [120] MemWrite
  - [124:123] MemToReg, [122] RegWrite
  - [157] LUOp, [156:125] LUData, [189:158] PC+4
  - [194:190] Shamt, [226:195] Imm32, [227] Branch, [229:228] RegDst, [230] Jump
  - All-zero bus = bubble.
- EX_MEM layout:
  - [31:0] result, [63:32] store data, [68:64] write reg
  - [69] RegWrite, [71:70] MemToReg, [72] MemWrite, [73] MemRead
  - [105:74] PC+4, [106] branch-taken.
- Forwarding, per operand (Rs, Rt), priority order:
  1. EX_MEM source: EX_MEM[69] & EX_MEM[68:64]==reg & reg!=0 selects EX_MEM[31:0].
  2. MEM_WB source: MEM_WB_RegWrite & MEM_WB_Rd==reg & reg!=0 selects MEM_WB_RdData.
  3. Otherwise the ID_EX field.
- Operand selection:
  - A = ALUSrc1 ? {27'b0,Shamt} : fwdRs.
  - B = ALUSrc2 ? Imm32 : fwdRt.
- ALUFun decode:
  - [5:4]=00 add/sub: ALUFun[0]=1 subtracts, 32-bit wrap.
  - [5:4]=01 logic by [3:0]: 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, 1010 pass A.
  - [5:4]=10 shift B by A[4:0] per [1:0]: 00 sll, 01 srl, 11 sra.
  - [5:4]=11 compare, result {31'b0,flag}, by [3:1]: 001 EQ, 000 NE, 010 LT, 110 LEZ(A), 101 LTZ(A), 111 GTZ(A).
  - LT is signed when Sign=1, unsigned otherwise.
  - Undefined codes give 0.
- Branch and jump:
  - EX_Branch = Branch & ALUout[0].
  - EX_Jump and EX_PC_Plus4 are pass-throughs.
  - Fully combinational from ID_EX, EX_MEM and the MEM_WB inputs. No added latency.
- Write register by RegDst: 00 Rd, 01 Rt, 10 RA_REG, 11 XP_REG.
- Result: MemToReg==10 selects PC+4; else LUOp selects LUData; else ALUout.
- Store data = fwdRt.
- Sequencing of EX_MEM, priority reset > flush > hold > load:
  - reset_b=0: EX_MEM=0 immediately.
  - EX_Flush: EX_MEM<=0.
  - EX_Hold: EX_MEM unchanged.
  - Otherwise: load the new value. Latency 1 cycle.
- Boundary cases:
  - Bubble input yields RegWrite=0, MemRead/MemWrite=0, EX_Branch=0.
  - Forwarding on register 0 is never applied.
  - Flush and hold asserted together: flush wins.
  - Reset asserted mid-hold clears immediately.
  - Derived outputs (EX_MEM_Rd etc.) read 0 after reset.

Decomposition:
- Shared pipeline package: ID_EX and EX_MEM field bit positions, ALUFun codes, RegDst/MemToReg codes.
- One sub-module: ex_alu (combinational: A, B, ALUFun, Sign -> 32-bit out).
- Forwarding muxes, result select and the register live in ex_stage.

Test Plan:
- add: Rs=5 data 7, Rt=6 data 3, ALUFun 000000 -> next edge EX_MEM[31:0]=10, write reg=Rd, RegWrite=1.
- Back-to-back dependency: EX_MEM holds Rd=5 result 0x100; incoming Rs=5 with stale data 7 -> operand 0x100. Add MEM_WB_Rd=5 data 0x200 simultaneously -> EX_MEM value wins.
- beq: Rs=Rt=0x1234, Branch=1, ALUFun 110011 -> EX_Branch=1, branch_target=ID_EX[119:88], EX_MEM[106]=1.
- bne with equal operands -> EX_Branch=0.
- slt: A=0xFFFFFFFF, B=1, Sign=1 -> result 1; Sign=0 -> result 0.
- jal: RegDst=10, MemToReg=10, PC+4=0x00400008 -> write reg 31, result 0x00400008.
- Control sequencing:
  - EX_Hold=1 for 2 cycles -> EX_MEM stable.
  - EX_Flush with EX_Hold -> EX_MEM=0.
  - reset_b low mid-operation -> EX_MEM=0 without a clock edge.
